// File: rtl/piso_ctrl_if.sv
// rtl/piso_ctrl_if.sv - parallel-in / serial-out handshake bundle
//
// Purpose: groups the word-side and bit-side handshakes of piso_ctrl.
// Signals:
//   in_valid/in_data/in_ready   parallel word handshake (upstream -> block)
//   ser_ready                   downstream accepts the current serial bit
//   ser_out/ser_valid           serial bit and its qualifier
//   frame_start/frame_last      first / last bit of a word
//   busy                        serialiser active or a word is held
// Modports: master = environment side, slave = piso_ctrl side.
interface piso_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             ser_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_last;
    logic             busy;

    modport master (
        output in_valid, in_data, ser_ready,
        input  in_ready, ser_out, ser_valid, frame_start, frame_last, busy
    );

    modport slave (
        input  in_valid, in_data, ser_ready,
        output in_ready, ser_out, ser_valid, frame_start, frame_last, busy
    );
endinterface

// File: rtl/piso_ctrl.sv
// rtl/piso_ctrl.sv - word serialiser with one-word holding register
//
// Purpose: accepts parallel words into a holding register and shifts them out
// one bit per accepted serial beat, optionally inserting idle cycles between
// words.
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-low reset
//   bus   piso_ctrl_if.slave (word handshake in, serial stream out, busy)
// Parameters: WIDTH (2..32), MSB_FIRST (1 = bit WIDTH-1 first),
//             GAP_CYCLES (0..15 idle cycles after each word).
module piso_ctrl #(
    parameter int WIDTH      = 4,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic         clk,
    input  logic         rst,
    piso_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    // Gap counter counts down to 0, so it is loaded with GAP_CYCLES-1.
    localparam logic [3:0]        GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;

    logic accept;
    logic advance;
    logic last_bit;
    logic load_word;
    logic ser_valid;

    // All outputs are gated by rst so they read 0 while reset is held,
    // independent of the register contents.
    assign bus.in_ready    = rst & ~hold_full_q;
    assign accept          = bus.in_valid & bus.in_ready;
    assign ser_valid       = rst & (state_q == SHIFT);
    assign advance         = ser_valid & bus.ser_ready;
    assign last_bit        = (bit_cnt_q == LAST_BIT);

    assign bus.ser_valid   = ser_valid;
    assign bus.ser_out     = ser_valid & ((MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0]);
    assign bus.frame_start = ser_valid & (bit_cnt_q == '0);
    assign bus.frame_last  = ser_valid & last_bit;
    assign bus.busy        = rst & ((state_q != IDLE) | hold_full_q);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        load_word   = 1'b0;

        // accept and load_word never coincide: accept needs hold empty,
        // load_word needs hold full.
        if (accept) begin
            hold_d      = bus.in_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load_word = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (advance) begin
                    if (last_bit) begin
                        if (GAP_CYCLES == 0) begin
                            // Chain straight into the held word with no bubble.
                            if (hold_full_q) begin
                                load_word = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            gap_cnt_d = GAP_LOAD;
                            state_d   = GAP;
                        end
                    end else begin
                        if (MSB_FIRST != 0) begin
                            shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        end else begin
                            shift_d = {1'b0, shift_q[WIDTH-1:1]};
                        end
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    if (hold_full_q) begin
                        load_word = 1'b1;
                        state_d   = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_word) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end
endmodule

// File: tb/tb_piso_ctrl.sv
// tb/tb_piso_ctrl.sv - self-checking bench for piso_ctrl (two configurations)
module tb_piso_ctrl;
    typedef struct packed {
        logic [3:0]  data;
        logic [31:0] edge_n;
    } word_t;

    localparam int GAP_I [2] = '{0, 2};
    localparam int MSB_I [2] = '{1, 0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       ser_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    piso_ctrl_if #(.WIDTH(4)) ifa ();
    piso_ctrl_if #(.WIDTH(4)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.ser_ready = ser_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.ser_ready = ser_ready;

    piso_ctrl #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(0)) dut_a (
        .clk (clk),
        .rst (rst_n),
        .bus (ifa)
    );

    piso_ctrl #(.WIDTH(4), .MSB_FIRST(0), .GAP_CYCLES(2)) dut_b (
        .clk (clk),
        .rst (rst_n),
        .bus (ifb)
    );

    logic sv [2];
    logic so [2];
    logic fs [2];
    logic fl [2];
    logic ir [2];
    logic bz [2];
    assign sv[0] = ifa.ser_valid;   assign sv[1] = ifb.ser_valid;
    assign so[0] = ifa.ser_out;     assign so[1] = ifb.ser_out;
    assign fs[0] = ifa.frame_start; assign fs[1] = ifb.frame_start;
    assign fl[0] = ifa.frame_last;  assign fl[1] = ifb.frame_last;
    assign ir[0] = ifa.in_ready;    assign ir[1] = ifb.in_ready;
    assign bz[0] = ifa.busy;        assign bz[1] = ifb.busy;

    // Reference model: queue of accepted words tagged with their accept edge,
    // bit position within the front word, and remaining idle cycles.
    word_t       mq [2][$];
    int          bit_idx [2];
    int          gap_left [2];
    logic [31:0] edge_n = 0;
    logic        acc [2];

    // Transferred-bit log for directed checks.
    logic [31:0] col [2];
    int          ncol [2];
    logic [31:0] first_e [2];
    logic [31:0] last_e [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // A word's first bit is valid on the cycle after the edge following its
    // accept edge at the earliest; a finished word is followed by GAP idle cycles.
    function automatic logic exp_valid(input int i);
        if (!rst_n || gap_left[i] != 0 || mq[i].size() == 0) return 1'b0;
        return mq[i][0].edge_n < edge_n;
    endfunction

    function automatic logic exp_bit(input int i);
        logic [3:0] w;
        w = mq[i][0].data;
        return (MSB_I[i] != 0) ? w[3 - bit_idx[i]] : w[bit_idx[i]];
    endfunction

    // Hold is occupied when two words are pending, or one that is not yet shifting.
    function automatic logic exp_ready(input int i);
        if (!rst_n) return 1'b0;
        return !(mq[i].size() >= 2 || (mq[i].size() == 1 && !exp_valid(i)));
    endfunction

    task automatic check_dut(input int i);
        string nm;
        logic  ev;
        nm = (i == 0) ? "a" : "b";
        ev = exp_valid(i);
        check({nm, "_valid"}, 32'(sv[i]), 32'(ev));
        check({nm, "_out"},   32'(so[i]), ev ? 32'(exp_bit(i)) : 32'd0);
        check({nm, "_start"}, 32'(fs[i]), 32'(ev && bit_idx[i] == 0));
        check({nm, "_last"},  32'(fl[i]), 32'(ev && bit_idx[i] == 3));
        check({nm, "_ready"}, 32'(ir[i]), 32'(exp_ready(i)));
        check({nm, "_busy"},  32'(bz[i]), 32'(rst_n && (mq[i].size() > 0 || gap_left[i] > 0)));
    endtask

    task automatic update(input int i);
        logic  ev;
        logic  er;
        word_t w;
        ev = exp_valid(i);
        er = exp_ready(i);
        acc[i] = in_valid && er;
        if (!rst_n) begin
            mq[i].delete();
            bit_idx[i]  = 0;
            gap_left[i] = 0;
        end else begin
            if (gap_left[i] > 0) gap_left[i]--;
            if (ev && ser_ready) begin
                if (ncol[i] == 0) first_e[i] = edge_n + 1;
                last_e[i] = edge_n + 1;
                col[i] = {col[i][30:0], exp_bit(i)};
                ncol[i]++;
                bit_idx[i]++;
                if (bit_idx[i] == 4) begin
                    void'(mq[i].pop_front());
                    bit_idx[i]  = 0;
                    gap_left[i] = GAP_I[i];
                end
            end
            if (acc[i]) begin
                w.data   = in_data;
                w.edge_n = edge_n + 1;
                mq[i].push_back(w);
            end
        end
    endtask

    // One clock: inputs are already set after a negedge; sample at +1,
    // advance the model across the coming posedge, wait for the next negedge.
    task automatic cycle();
        #1;
        check_dut(0);
        check_dut(1);
        update(0);
        update(1);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic clr_col();
        for (int i = 0; i < 2; i++) begin
            col[i]  = 0;
            ncol[i] = 0;
            first_e[i] = 0;
            last_e[i]  = 0;
        end
    endtask

    task automatic offer(input int i, input logic [3:0] d);
        logic done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 20 && !done; k++) begin
            cycle();
            done = acc[i];
        end
        in_valid = 1'b0;
        if (!done) check("offer_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_bits(input int i, input int n);
        for (int k = 0; k < 20 && ncol[i] < n; k++) cycle();
        check("wait_bits", 32'(ncol[i]), 32'(n));
    endtask

    task automatic drain();
        logic idle;
        idle = 1'b0;
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        for (int k = 0; k < 60 && !idle; k++) begin
            idle = mq[0].size() == 0 && mq[1].size() == 0 && gap_left[0] == 0 && gap_left[1] == 0;
            if (!idle) cycle();
        end
        if (!idle) check("drain_timeout", 32'd0, 32'd1);
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            bit_idx[i] = 0;
            gap_left[i] = 0;
            acc[i] = 1'b0;
        end
        clr_col();
        @(negedge clk);

        // Reset with a word offered: nothing accepted, all outputs low.
        rst_n = 1'b0; in_valid = 1'b1; in_data = 4'hF;
        cycle();
        cycle();
        rst_n = 1'b1; in_valid = 1'b0;
        cycle();
        check("rst_ready_after", 32'(ir[0]), 32'd1);
        check("rst_busy_after", 32'(bz[0]), 32'd0);

        // Single word, MSB first.
        clr_col();
        ser_ready = 1'b1;
        offer(0, 4'b1010);
        drain();
        check("single_bits", col[0], 32'b1010);
        check("single_cnt", 32'(ncol[0]), 32'd4);

        // Back-to-back words with no bubble.
        clr_col();
        offer(0, 4'b1010);
        offer(0, 4'b0110);
        drain();
        check("b2b_bits", col[0], 32'b10100110);
        check("b2b_span", last_e[0] - first_e[0] + 1, 32'd8);

        // LSB first with a 2-cycle gap.
        clr_col();
        offer(1, 4'b0001);
        offer(1, 4'b1000);
        drain();
        check("gap_bits", col[1], 32'b10000001);
        check("gap_span", last_e[1] - first_e[1] + 1, 32'd10);

        // Backpressure while the second bit is presented.
        clr_col();
        offer(0, 4'b1100);
        wait_bits(0, 1);
        ser_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_hold", 32'(so[0]), 32'd1);
            cycle();
        end
        drain();
        check("bp_bits", col[0], 32'b1100);
        check("bp_cnt", 32'(ncol[0]), 32'd4);

        // Reset mid-frame with a second word held.
        clr_col();
        offer(0, 4'b1011);
        offer(0, 4'b1110);
        wait_bits(0, 2);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        check("mid_rst_valid", 32'(sv[0]), 32'd0);
        check("mid_rst_ready", 32'(ir[0]), 32'd1);
        check("mid_rst_busy", 32'(bz[0]), 32'd0);
        cycle();
        clr_col();
        offer(0, 4'b0101);
        drain();
        check("mid_rst_bits", col[0], 32'b0101);
        check("mid_rst_cnt", 32'(ncol[0]), 32'd4);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = 4'($urandom);
            ser_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        rst_n = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/piso_ctrl.md
PISO_CTRL -- requirements
Module: piso_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, number of bits per word; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 Parameter GAP_CYCLES, default 0, number of idle cycles inserted after each frame; legal range 0..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 in_valid  input  1  upstream offers a parallel word.
REQ-007 in_data  input  WIDTH  parallel word.
REQ-008 in_ready  output  1  block can accept a word; a word transfers on any edge where in_valid and in_ready are both 1.
REQ-009 ser_ready  input  1  downstream accepts the current serial bit.
REQ-010 ser_out  output  1  current serial bit.
REQ-011 ser_valid  output  1  ser_out carries a data bit.
REQ-012 frame_start  output  1  high with the first bit of each word.
REQ-013 frame_last  output  1  high with the last bit of each word.
REQ-014 busy  output  1  high when the FSM is not IDLE or the holding register is full.

Function
REQ-015 The block SHALL contain a one-word holding register (hold, hold_full), a WIDTH-bit shift register, a bit counter, a gap counter and an FSM with states IDLE, SHIFT and GAP.
REQ-016 in_ready SHALL equal rst AND NOT hold_full (combinational); an accepted word SHALL be written to hold and SHALL set hold_full.
REQ-017 IDLE with hold_full=1: on the next edge the FSM SHALL load the shifter from hold, clear hold_full, clear the bit counter and go to SHIFT.
REQ-018 SHIFT: ser_valid=1; ser_out SHALL be shifter[WIDTH-1] if MSB_FIRST=1, else shifter[0].
REQ-019 A bit SHALL advance only on an edge with ser_valid=1 and ser_ready=1; when ser_ready=0, the shifter, the counters and ser_out SHALL hold.
REQ-020 frame_start SHALL be high in SHIFT when bit count = 0; frame_last SHALL be high in SHIFT when bit count = WIDTH-1.
REQ-021 When the last bit advances: if GAP_CYCLES=0 and hold_full=1, the next word SHALL load on that same edge and the FSM SHALL stay in SHIFT (no bubble); if GAP_CYCLES=0 and hold_full=0, the FSM SHALL go to IDLE; if GAP_CYCLES>0, the FSM SHALL load the gap counter and go to GAP.
REQ-022 GAP: ser_valid=0 for exactly GAP_CYCLES cycles; at the end of the gap, the FSM SHALL load from hold and go to SHIFT if hold_full=1, else go to IDLE.
REQ-023 A word accepted in the same edge that hold is emptied SHALL NOT occur, because in_ready is 0 while hold_full=1.
REQ-024 ser_out SHALL be 0 whenever ser_valid=0.
REQ-025 Latency: word accepted at edge E0 in IDLE → its first bit is valid in the cycle after edge E0+1.

Reset
REQ-026 While rst=0 on an edge: FSM SHALL go to IDLE, and hold_full, the shifter, the bit counter and the gap counter SHALL all clear to 0.
REQ-027 While rst=0: in_ready, ser_valid, ser_out, frame_start, frame_last and busy SHALL all be 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame and discard hold; no partial bits SHALL appear after reset is released.

Verification
REQ-029 Reset check: rst=0 for 2 cycles with in_valid=1 and in_data=4'hF → no accept; all outputs 0; after rst=1, in_ready=1.
REQ-030 Single word, WIDTH=4, MSB_FIRST=1, in_data=4'b1010, ser_ready=1 → ser_out=1,0,1,0 on 4 consecutive ser_valid cycles; frame_start on bit 1; frame_last on bit 4; then IDLE with busy=0.
REQ-031 Back-to-back, GAP_CYCLES=0, words 4'b1010 then 4'b0110 → 8 contiguous ser_valid cycles carrying 1,0,1,0,0,1,1,0; in_ready reasserts when the second word moves into the shifter.
REQ-032 Gap and LSB-first: GAP_CYCLES=2, MSB_FIRST=0, words 4'b0001 then 4'b1000 → bits 1,0,0,0, then exactly 2 cycles with ser_valid=0, then bits 0,0,0,1.
REQ-033 Backpressure: ser_ready=0 for 3 cycles after bit 2 of 4'b1100 → ser_out holds 1 for those 3 cycles; the full sequence received is 1,1,0,0 with no bit lost or duplicated.
REQ-034 Mid-frame reset: rst=0 for 1 cycle after bit 2 of 4'b1011, with a second word held in hold → ser_valid=0 the next cycle; hold is empty; a new word 4'b0101 then serialises as 0,1,0,1 from bit 0.
